// File: rtl/csa_accumulator_if.sv
// ----------------------------------------------------------------------------
// csa_accumulator_if
// Beat-in / result-out bundle for csa_accumulator.
//   in_valid, in_ready, in_last, pv_s, pv_c : one sum/carry pair per beat
//   out_valid, out_ready, out_data, out_beats : resolved frame result
// Modports:
//   slave  - the accumulator side (consumes beats, produces results)
//   master - the surrounding logic (CSA tree upstream, result sink downstream)
// ----------------------------------------------------------------------------
interface csa_accumulator_if #(
  parameter int MAX   = 7,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [MAX-1:0]   pv_s;
  logic [MAX-1:0]   pv_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [7:0]       out_beats;

  modport slave (
    input  in_valid, in_last, pv_s, pv_c, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );

  modport master (
    output in_valid, in_last, pv_s, pv_c, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/csa_accumulator.sv
// ----------------------------------------------------------------------------
// csa_accumulator
// Carry-save frame accumulator. Each accepted beat folds a sum/carry pair into
// a carry-save accumulator through a 4:2 compressor (no carry propagation on
// the input path). The beat flagged in_last closes the frame; the accumulator
// is then resolved CHUNK bits per cycle by a small carry-propagate adder and
// the binary result is offered on a valid/ready output.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - csa_accumulator_if.slave:
//            in_valid/in_ready/in_last/pv_s/pv_c  beat input
//            out_valid/out_ready/out_data/out_beats result output
//
// Build option:
//   CSA_ACC_BEATCNT_EN - when defined, an 8-bit saturating beat counter drives
//                        out_beats; otherwise out_beats is tied to zero.
// ----------------------------------------------------------------------------
module csa_accumulator #(
  parameter int MAX   = 7,
  parameter int ACC_W = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  csa_accumulator_if.slave bus
);

  localparam int NCH    = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NCH * CHUNK;
  localparam int CIDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  // 3:2 compressor over full accumulator width; returns {carry, sum}.
  // The carry vector is pre-shifted and its top bit dropped (mod 2^ACC_W).
  function automatic logic [2*ACC_W-1:0] csa32(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    logic [ACC_W-1:0] sum_v;
    logic [ACC_W-1:0] maj_v;
    sum_v = a ^ b ^ c;
    maj_v = (a & b) | (a & c) | (b & c);
    return {maj_v[ACC_W-2:0], 1'b0, sum_v};
  endfunction

  state_t              state_r;
  logic [ACC_W-1:0]    acc_sum_r;
  logic [ACC_W-1:0]    acc_car_r;
  logic [ACC_W-1:0]    res_r;
  logic [CIDX_W-1:0]   chunk_idx_r;
  logic                cin_r;
  logic                in_ready_r;
  logic                out_valid_r;

  logic [ACC_W-1:0]    pv_s_ext_s;
  logic [ACC_W-1:0]    pv_c_ext_s;
  logic [2*ACC_W-1:0]  l1_s;
  logic [2*ACC_W-1:0]  l2_s;
  logic [PAD_W-1:0]    sum_pad_s;
  logic [PAD_W-1:0]    car_pad_s;
  logic [PAD_W-1:0]    res_pad_s;
  logic [CHUNK:0]      chunk_add_s;
  logic [ACC_W-1:0]    res_next_s;
  int                  chunk_base_s;
  logic                beat_acc_s;
  logic                out_hs_s;

  // in_ready is only high in ACC, so it alone qualifies a beat.
  assign beat_acc_s = bus.in_valid & in_ready_r;
  assign out_hs_s   = out_valid_r & bus.out_ready;

  // 4:2 compression of the accumulator with the incoming pair, and the
  // chunk adder used while resolving.
  always_comb begin
    pv_s_ext_s = '0;
    pv_s_ext_s[MAX-1:0] = bus.pv_s;
    pv_c_ext_s = '0;
    pv_c_ext_s[MAX-1:0] = bus.pv_c;

    l1_s = csa32(acc_sum_r, acc_car_r, pv_s_ext_s);
    l2_s = csa32(l1_s[ACC_W-1:0], l1_s[2*ACC_W-1:ACC_W], pv_c_ext_s);

    // Padding lets the final chunk be handled like the others; bits above
    // ACC_W are zero on input and discarded on output.
    chunk_base_s = int'(chunk_idx_r) * CHUNK;
    sum_pad_s = '0;
    sum_pad_s[ACC_W-1:0] = acc_sum_r;
    car_pad_s = '0;
    car_pad_s[ACC_W-1:0] = acc_car_r;

    chunk_add_s = {1'b0, sum_pad_s[chunk_base_s +: CHUNK]}
                + {1'b0, car_pad_s[chunk_base_s +: CHUNK]}
                + {{CHUNK{1'b0}}, cin_r};

    res_pad_s = '0;
    res_pad_s[ACC_W-1:0] = res_r;
    res_pad_s[chunk_base_s +: CHUNK] = chunk_add_s[CHUNK-1:0];
    res_next_s = res_pad_s[ACC_W-1:0];
  end

  // Control FSM with accumulator, resolve datapath and registered handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_ACC;
      acc_sum_r   <= '0;
      acc_car_r   <= '0;
      res_r       <= '0;
      chunk_idx_r <= '0;
      cin_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (beat_acc_s) begin
            acc_sum_r <= l2_s[ACC_W-1:0];
            acc_car_r <= l2_s[2*ACC_W-1:ACC_W];
            if (bus.in_last) begin
              state_r     <= ST_RESOLVE;
              in_ready_r  <= 1'b0;
              chunk_idx_r <= '0;
              cin_r       <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          res_r <= res_next_s;
          if (chunk_idx_r == LAST_CHUNK) begin
            // Carry out of the top chunk falls off: result is mod 2^ACC_W.
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
            chunk_idx_r <= '0;
            cin_r       <= 1'b0;
          end else begin
            chunk_idx_r <= chunk_idx_r + 1'b1;
            cin_r       <= chunk_add_s[CHUNK];
          end
        end
        ST_OUT: begin
          if (out_hs_s) begin
            state_r     <= ST_ACC;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_sum_r   <= '0;
            acc_car_r   <= '0;
            cin_r       <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          acc_sum_r   <= '0;
          acc_car_r   <= '0;
          chunk_idx_r <= '0;
          cin_r       <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = res_r;

`ifdef CSA_ACC_BEATCNT_EN
  logic [7:0] beats_r;

  // Saturating per-frame beat counter; only moves in ACC or on the handshake,
  // so it is stable while the result is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_r <= 8'd0;
    end else if (out_hs_s) begin
      beats_r <= 8'd0;
    end else if (beat_acc_s && (beats_r != 8'hFF)) begin
      beats_r <= beats_r + 8'd1;
    end
  end

  assign bus.out_beats = beats_r;
`else
  assign bus.out_beats = 8'd0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// ----------------------------------------------------------------------------
// tb_csa_accumulator
// Self-checking bench for csa_accumulator. Expected results come from a plain
// arithmetic model: the frame sum of all (pv_s + pv_c) modulo 2^16, and the
// beat count saturated at 255 (zero when the counter is not built).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csa_accumulator;

  localparam int MAX   = 7;
  localparam int ACC_W = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] q_s[$];
  logic [6:0] q_c[$];

  csa_accumulator_if #(.MAX(MAX), .ACC_W(ACC_W)) bus();

  csa_accumulator #(.MAX(MAX), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_sum();
    int unsigned t = 0;
    foreach (q_s[i]) t += int'(q_s[i]) + int'(q_c[i]);
    return 16'(t);
  endfunction

  function automatic logic [7:0] model_beats(input int n);
`ifdef CSA_ACC_BEATCNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  // Sends q_s/q_c as one frame; returns just after the edge taking the last beat.
  task automatic send_frame(input int gap_pct, output bit ok);
    int w;
    ok = 1'b1;
    for (int i = 0; i < q_s.size(); i++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
          bus.in_valid = 1'b0;
          bus.pv_s = 7'($urandom);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.pv_s     = q_s[i];
      bus.pv_c     = q_c[i];
      bus.in_last  = (i == q_s.size() - 1);
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) ok = 1'b0;
      @(posedge clk);
    end
  endtask

  // Waits for out_valid; lat counts edges after the last accepted beat.
  task automatic wait_result(output int lat, output logic [15:0] d,
                             output logic [7:0] b, output bit seen,
                             output logic rdy_after);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rdy_after = bus.in_ready;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    seen = bus.out_valid;
    d    = bus.out_data;
    b    = bus.out_beats;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    n_checks++; if (bus.out_beats !== 8'h00) begin n_fail++; $display("FAIL reset_out_beats: got %h expected 00", bus.out_beats); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    bit ok, seen; int lat; logic [15:0] d; logic [7:0] b; logic rdy;
    q_s = '{7'h05}; q_c = '{7'h0A};
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (!ok || !seen) begin n_fail++; $display("FAIL single_handshake: accepted %b valid %b expected 1 1", ok, seen); end
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_drop: got %b expected 0", rdy); end
    n_checks++; if (lat != NCH) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, NCH); end
    n_checks++; if (d !== 16'h000F) begin n_fail++; $display("FAIL single_data: got %h expected 000f", d); end
    n_checks++; if (b !== model_beats(1)) begin n_fail++; $display("FAIL single_beats: got %0d expected %0d", b, model_beats(1)); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_out: got %b expected 0", bus.in_ready); end
    handshake();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_after_hs: valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.out_data !== 16'h000F) begin n_fail++; $display("FAIL single_data_held: got %h expected 000f", bus.out_data); end
    n_checks++; if (bus.out_beats !== 8'h00) begin n_fail++; $display("FAIL single_beats_clear: got %0d expected 0", bus.out_beats); end
  endtask

  task automatic test_back_to_back();
    bit ok, seen; int lat; logic [15:0] d; logic [7:0] b; logic rdy;
    q_s = '{7'h7F, 7'h7F, 7'h7F}; q_c = '{7'h7F, 7'h7F, 7'h7F};
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (!ok || !seen || lat != NCH) begin n_fail++; $display("FAIL b2b_timing: accepted %b valid %b latency %0d expected 1 1 %0d", ok, seen, lat, NCH); end
    n_checks++; if (d !== 16'h02FA) begin n_fail++; $display("FAIL b2b_data: got %h expected 02fa", d); end
    n_checks++; if (b !== model_beats(3)) begin n_fail++; $display("FAIL b2b_beats: got %0d expected %0d", b, model_beats(3)); end
    handshake();
  endtask

  task automatic test_wrap();
    bit ok, seen; int lat; logic [15:0] d; logic [7:0] b; logic rdy;
    q_s.delete(); q_c.delete();
    for (int i = 0; i < 259; i++) begin q_s.push_back(7'h7F); q_c.push_back(7'h7F); end
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (!ok || !seen) begin n_fail++; $display("FAIL wrap_handshake: accepted %b valid %b expected 1 1", ok, seen); end
    n_checks++; if (d !== 16'h00FA) begin n_fail++; $display("FAIL wrap_data: got %h expected 00fa", d); end
    n_checks++; if (b !== model_beats(259)) begin n_fail++; $display("FAIL wrap_beats: got %0d expected %0d", b, model_beats(259)); end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok, seen; int lat; logic [15:0] d; logic [7:0] b; logic rdy;
    q_s = '{7'h11, 7'h22}; q_c = '{7'h33, 7'h44};
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (d !== model_sum() || !seen) begin n_fail++; $display("FAIL bp_first_data: got %h valid %b expected %h 1", d, seen, model_sum()); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.pv_s = 7'($urandom);
      bus.pv_c = 7'($urandom);
      bus.in_last = 1'($urandom);
      @(negedge clk);
      n_checks++; if (bus.out_data !== d || bus.out_beats !== b) begin n_fail++; $display("FAIL bp_stable: data %h beats %0d expected %h %0d", bus.out_data, bus.out_beats, d, b); end
      n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_flags: ready %b valid %b expected 0 1", bus.in_ready, bus.out_valid); end
    end
    handshake();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    q_s = '{7'd1, 7'd0}; q_c = '{7'd0, 7'd2};
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (d !== 16'd3 || !seen) begin n_fail++; $display("FAIL bp_next_data: got %h valid %b expected 0003 1", d, seen); end
    n_checks++; if (b !== model_beats(2)) begin n_fail++; $display("FAIL bp_next_beats: got %0d expected %0d", b, model_beats(2)); end
    handshake();
  endtask

  task automatic test_reset_mid_resolve();
    bit ok, seen; int lat; int pulses; logic [15:0] d; logic [7:0] b; logic rdy;
    q_s = '{7'h10, 7'h05}; q_c = '{7'h20, 7'h06};
    send_frame(0, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.out_data !== 16'h0000 || bus.out_beats !== 8'h00) begin n_fail++; $display("FAIL rst_mid_outputs: data %h beats %0d expected 0000 0", bus.out_data, bus.out_beats); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: got %0d valid cycles expected 0", pulses); end
    q_s = '{7'd3, 7'd0}; q_c = '{7'd0, 7'd4};
    send_frame(0, ok);
    wait_result(lat, d, b, seen, rdy);
    n_checks++; if (d !== 16'd7 || !seen || lat != NCH) begin n_fail++; $display("FAIL rst_mid_next: data %h valid %b latency %0d expected 0007 1 %0d", d, seen, lat, NCH); end
    n_checks++; if (b !== model_beats(2)) begin n_fail++; $display("FAIL rst_mid_beats: got %0d expected %0d", b, model_beats(2)); end
    handshake();
  endtask

  task automatic test_random_frames();
    bit ok, seen; int lat; int n; logic [15:0] d; logic [7:0] b; logic rdy;
    for (int f = 0; f < 12; f++) begin
      q_s.delete(); q_c.delete();
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        q_s.push_back(7'($urandom));
        q_c.push_back(7'($urandom));
      end
      send_frame(30, ok);
      wait_result(lat, d, b, seen, rdy);
      n_checks++; if (!ok || !seen || lat != NCH) begin n_fail++; $display("FAIL rand_timing frame %0d: accepted %b valid %b latency %0d expected 1 1 %0d", f, ok, seen, lat, NCH); end
      n_checks++; if (d !== model_sum()) begin n_fail++; $display("FAIL rand_data frame %0d: got %h expected %h", f, d, model_sum()); end
      n_checks++; if (b !== model_beats(n)) begin n_fail++; $display("FAIL rand_beats frame %0d: got %0d expected %0d", f, b, model_beats(n)); end
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.pv_s      = 7'h00;
    bus.pv_c      = 7'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_mid_resolve();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Carry-save frame accumulator placed directly downstream of the CSA reduction tree. Each beat accepts one sum/carry vector pair, `pv_s` and `pv_c`, from the tree. The block folds the pair into an accumulator that stays in carry-save form, so no carry propagates on the input path. On the last beat of a frame it resolves the accumulator into a binary result with a chunked carry-propagate adder, then presents the result on a valid/ready output.

## Interface
Parameters:
- `MAX`, 7: width of `pv_s`/`pv_c`, matching the tree's `MAX`.
- `ACC_W`, 16: accumulator and result width; `ACC_W` must be ≥ `MAX+1`.
- `CHUNK`, 4: bits resolved per cycle. `NCH = ceil(ACC_W/CHUNK)`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: beat valid.
- `in_ready`, out, 1: beat accepted when `in_valid & in_ready` at a rising `clk` edge.
- `in_last`, in, 1: accepted beat closes the frame.
- `pv_s`, in, `MAX`: sum vector from the CSA tree.
- `pv_c`, in, `MAX`: carry vector from the CSA tree.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result consumed when `out_valid & out_ready` at a rising `clk` edge.
- `out_data`, out, `ACC_W`: resolved frame sum, mod 2^`ACC_W`.
- `out_beats`, out, 8: beats in the frame (see Configuration).

## Operation
- States: ACC, RESOLVE, OUT.
- Reset state is ACC.
- Reset values:
  - `acc_s = acc_c = 0`; resolve register, chunk index and carry-in all 0.
  - `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_beats = 0`.
- ACC:
  - `in_ready = 1`.
  - On an accepted beat, `pv_s` and `pv_c` are zero-extended to `ACC_W`.
  - A 4:2 compression (two 3:2 layers) of `acc_s`, `acc_c`, `pv_s` and `pv_c` produces the new `acc_s` and `acc_c`.
  - Carry vectors shift left by 1; any bit shifted past `ACC_W-1` is dropped, so arithmetic is mod 2^`ACC_W`.
  - If `in_last = 1`, the state goes to RESOLVE on the same edge, and the accumulator includes that beat.
- RESOLVE:
  - `in_ready = 0`.
  - On edge k (k = 0..`NCH-1`), the block computes chunk k of `acc_s` + chunk k of `acc_c` + carry-in, where chunk k is bits `[k*CHUNK +: CHUNK]`.
  - The chunk result is written to the same bit positions of the result register, and the chunk carry-out is registered as the next carry-in.
  - The last chunk is truncated at `ACC_W`, and its carry-out is discarded.
  - After chunk `NCH-1` the state goes to OUT.
- OUT:
  - `out_valid = 1`; `out_data` and `out_beats` are held stable while `out_ready = 0`.
  - On the output handshake, `acc_s`, `acc_c`, the carry-in and the beat count clear, and the state goes to ACC.
  - `out_data` keeps its last value until it is overwritten by the next resolve.
- A frame of zero beats is impossible: a frame only ends on an accepted beat with `in_last = 1`.
- `in_valid` while `in_ready = 0` is ignored; the upstream source holds its data.
- Asynchronous `rst` in any state, including mid-RESOLVE or while OUT is stalled, immediately forces the reset values. The partial frame is discarded and no result is emitted.

## Timing
- Input throughput: 1 beat per cycle in ACC. There is no combinational path from `pv_s`/`pv_c` to any output.
- Latency: if the last beat is accepted at edge E0, `out_valid` rises after edge E0+`NCH`, i.e. `NCH` cycles later (4 with defaults).
- `in_ready` drops in the cycle after edge E0 and returns to 1 in the cycle after the output handshake edge. This gives a minimum frame-to-frame gap of `NCH+1` cycles.
- `out_valid` depends only on state, never combinationally on `out_ready`.

## Configuration
- `CSA_ACC_BEATCNT_EN` defined:
  - An 8-bit counter increments on each accepted beat, saturating at 255.
  - `out_beats` carries the count for the frame and clears on the output handshake.
- `CSA_ACC_BEATCNT_EN` undefined: the counter is not built and `out_beats` is tied to 0.

## Test plan
- Single beat: `pv_s = 7'h05`, `pv_c = 7'h0A`, `in_last = 1` → `out_valid` 4 cycles later, `out_data = 16'h000F`, `out_beats = 1` (macro defined).
- Three back-to-back beats, each `pv_s = pv_c = 7'h7F`, with `in_last` on the third → `out_data = 16'h02FA` (762), `out_beats = 3`.
- Wrap-around: 259 beats of `7'h7F`/`7'h7F` (259 × 254 = 65786) → `out_data = 16'h00FA`, `out_beats = 255` (saturated).
- Backpressure:
  - hold `out_ready = 0` for 5 cycles in OUT → `out_data` stable, `in_ready = 0`;
  - offered beats are not absorbed and `in_valid` is ignored;
  - after the handshake, a new frame `1 + 2` → `out_data = 3`.
- Reset mid-RESOLVE: assert `rst` on the second RESOLVE cycle → outputs take their reset values immediately, and `out_valid` never pulses.
  - A following frame `3 + 4` → `out_data = 7`.
- Macro undefined: rerun the three-beat case → `out_data = 16'h02FA`, `out_beats = 0`.
